// File: rtl/burst_line_port_if.sv
// Client request/response and burst RAM command signals
// for the cache line port.
interface burst_line_port_if #(
  parameter int DataBitWidth    = 64,
  parameter int AddressBitWidth = 4,
  parameter int BurstDataCount  = 4
);
  localparam int LineAddrBits =
    AddressBitWidth - $clog2(BurstDataCount);
  localparam int LineBits = DataBitWidth * BurstDataCount;

  logic                      req_valid;
  logic                      req_write;
  logic [LineAddrBits-1:0]   req_line_addr;
  logic [LineBits-1:0]       req_wr_line;
  logic                      req_ready;
  logic                      rsp_valid;
  logic                      rsp_error;
  logic [LineBits-1:0]       rsp_rd_line;

  logic                      cmd;
  logic                      cmd_en;
  logic [AddressBitWidth-1:0] addr;
  logic [DataBitWidth-1:0]   wr_data;
  logic [DataBitWidth/8-1:0] data_mask;
  logic [DataBitWidth-1:0]   rd_data;
  logic                      rd_data_valid;
  logic                      init_calib;
  logic                      busy;

  modport master (
    input  req_valid, req_write, req_line_addr, req_wr_line,
    output req_ready, rsp_valid, rsp_error, rsp_rd_line,
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, init_calib, busy
  );

  modport slave (
    output req_valid, req_write, req_line_addr, req_wr_line,
    input  req_ready, rsp_valid, rsp_error, rsp_rd_line,
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, init_calib, busy
  );
endinterface

// File: rtl/burst_line_port.sv
// Moves whole cache lines to and from burst RAM, one
// request at a time, with a read timeout.
module burst_line_port #(
  parameter int DataBitWidth      = 64,
  parameter int AddressBitWidth   = 4,
  parameter int BurstDataCount    = 4,
  parameter int ReadTimeoutCycles = 64
) (
  input logic clk,
  input logic rst_n,
  burst_line_port_if.master bus
);
  localparam int WordSel  = $clog2(BurstDataCount);
  localparam int LineBits = DataBitWidth * BurstDataCount;
  localparam int CW       = WordSel + 1;
  localparam int TW       = $clog2(ReadTimeoutCycles + 1);

  localparam logic [CW-1:0] WEnd =
    CW'(BurstDataCount);
  localparam logic [WordSel-1:0] RLast =
    WordSel'(BurstDataCount - 1);
  localparam logic [TW-1:0] TLast =
    TW'(ReadTimeoutCycles - 1);

  typedef enum logic [1:0] {
    WaitCalib,
    Idle,
    WriteBurst,
    ReadWait
  } state_t;

  state_t              state;
  logic [LineBits-1:0] wr_line;
  logic [LineBits-1:0] rd_line;
  logic [CW-1:0]       wr_idx;
  logic [WordSel-1:0]  rd_idx;
  logic [TW-1:0]       tmo;
  logic                accept;
  logic                rd_last;

  assign bus.req_ready = (state == Idle)
                       && bus.init_calib
                       && !bus.busy;
  assign accept    = bus.req_valid && bus.req_ready;
  assign rd_last   = bus.rd_data_valid && (rd_idx == RLast);
  assign bus.data_mask = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= WaitCalib;
      bus.cmd_en      <= 1'b0;
      bus.cmd         <= 1'b0;
      bus.addr        <= '0;
      bus.wr_data     <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_error   <= 1'b0;
      bus.rsp_rd_line <= '0;
      wr_line         <= '0;
      rd_line         <= '0;
      wr_idx          <= '0;
      rd_idx          <= '0;
      tmo             <= '0;
    end else begin
      bus.cmd_en    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_error <= 1'b0;
      unique case (state)
        WaitCalib: begin
          if (bus.init_calib) state <= Idle;
        end
        Idle: begin
          if (!bus.init_calib) begin
            state <= WaitCalib;
          end else if (accept) begin
            bus.cmd_en <= 1'b1;
            bus.cmd    <= bus.req_write;
            bus.addr   <= {bus.req_line_addr,
                           {WordSel{1'b0}}};
            wr_line    <= bus.req_wr_line;
            if (bus.req_write) begin
              bus.wr_data <=
                bus.req_wr_line[DataBitWidth-1:0];
              wr_idx <= CW'(1);
              state  <= WriteBurst;
            end else begin
              rd_idx <= '0;
              tmo    <= '0;
              state  <= ReadWait;
            end
          end
        end
        WriteBurst: begin
          if (wr_idx == WEnd) begin
            bus.rsp_valid <= 1'b1;
            state         <= Idle;
          end else begin
            bus.wr_data <= wr_line[int'(wr_idx)*DataBitWidth
                                   +: DataBitWidth];
            wr_idx <= wr_idx + CW'(1);
          end
        end
        ReadWait: begin
          tmo <= tmo + TW'(1);
          if (bus.rd_data_valid) begin
            rd_line[int'(rd_idx)*DataBitWidth
                    +: DataBitWidth] <= bus.rd_data;
            rd_idx <= rd_idx + WordSel'(1);
          end
          // a last word landing on the timeout cycle still completes
          if (rd_last) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rd_line <= {bus.rd_data,
              rd_line[LineBits-DataBitWidth-1:0]};
            state <= Idle;
          end else if (tmo == TLast) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= 1'b1;
            state         <= Idle;
          end
        end
        default: state <= WaitCalib;
      endcase
    end
  end
endmodule
